// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Unsigned N-bit dividend / M-bit divisor -> N-bit quotient, M-bit remainder.
// Controlled by a start/busy/done handshake; results are held between completions.
module div_seq #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [M-1:0] r,
    output logic         dbz
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Control state and registered outputs
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  q_q;
    logic [M-1:0]  r_q;
    logic          dbz_q;

    // Working datapath registers (not reset: always loaded on accept before use)
    logic [M:0]    rem_q;
    logic [N-1:0]  sreg_q;
    logic [M-1:0]  dvs_q;
    logic [M-1:0]  dvd_lo_q;
    logic          zero_q;

    // Next-state of one restoring step
    logic [M:0]    shifted;
    logic [M:0]    trial;
    logic [M:0]    rem_d;
    logic [N-1:0]  sreg_d;
    logic          accept;

    assign accept = rst_n && (state_q == IDLE) && start;

    // One restoring step: shift in the next dividend bit, try to subtract the divisor.
    // The partial remainder never exceeds divisor-1, so trial fits in M+1 bits and
    // its MSB is the sign.
    always_comb begin
        shifted = {rem_q[M-1:0], sreg_q[N-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_d   = trial[M] ? shifted : trial;
        sreg_d  = {sreg_q[N-2:0], ~trial[M]};
    end

    // Datapath: load operands on accept, iterate while running
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q    <= '0;
            sreg_q   <= dividend;
            dvs_q    <= divisor;
            dvd_lo_q <= dividend[M-1:0];
            zero_q   <= (divisor == '0);
        end else if (state_q == RUN) begin
            rem_q  <= rem_d;
            sreg_q <= sreg_d;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= zero_q;
                        // A zero divisor discards the iteration result
                        if (zero_q) begin
                            q_q <= '1;
                            r_q <= dvd_lo_q;
                        end else begin
                            q_q <= sreg_d;
                            r_q <= rem_d[M-1:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq. Stimulus pushes expected results into
// a queue; an independent monitor pops and compares on every done pulse.
module tb_div_seq;

    localparam int N = 8;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [M-1:0] divisor = '0;
    logic         busy, done, dbz;
    logic [N-1:0] q;
    logic [M-1:0] r;

    typedef struct packed {
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    div_seq #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected done, got q=%0d r=%0d dbz=%0d, required no completion", q, r, dbz);
            end else begin
                e = exp_q.pop_front();
                if (q !== e.q || r !== e.r || dbz !== e.dbz) begin
                    errors++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0d, required q=%0d r=%0d dbz=%0d",
                             q, r, dbz, e.q, e.r, e.dbz);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge
    task automatic start_op(input int a, input int b, input int eq, input int er, input int ed);
        exp_t e;
        e.q = N'(eq); e.r = M'(er); e.dbz = ed[0];
        exp_q.push_back(e);
        dividend = N'(a);
        divisor  = M'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Wait for done after accept; verifies latency and busy stays high meanwhile
    task automatic wait_done();
        int lat = -1;
        int busy_bad = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (done) begin
                lat = j;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
        check("latency", lat, N);
        check("busy_window", busy_bad, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dbz", dbz, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation
        start_op(143, 11, 13, 0, 0);
        check("busy_after_accept", busy, 1);
        wait_done();
        @(negedge clk);

        start_op(200, 7, 28, 4, 0);
        wait_done();
        @(negedge clk);
        check("done_falls", done, 0);
        check("hold_q", q, 28);
        check("hold_r", r, 4);
        repeat (3) @(negedge clk);
        check("hold_q_later", q, 28);

        // Edge operands
        start_op(255, 1, 255, 0, 0);  wait_done(); @(negedge clk);
        start_op(0, 15, 0, 0, 0);     wait_done(); @(negedge clk);
        start_op(255, 15, 17, 0, 0);  wait_done(); @(negedge clk);
        start_op(254, 15, 16, 14, 0); wait_done(); @(negedge clk);

        // Divide by zero, then a normal op clears dbz
        start_op(100, 0, 255, 4, 1);  wait_done(); @(negedge clk);
        start_op(9, 3, 3, 0, 0);      wait_done(); @(negedge clk);

        // start mid-operation is ignored; start in done cycle is accepted
        start_op(200, 7, 28, 4, 0);
        repeat (3) @(negedge clk);
        dividend = 8'd50; divisor = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        // accept edge was 4 negedges ago; done expected 4 more cycles later
        begin
            int lat = -1;
            for (int j = 1; j <= 12; j++) begin
                @(negedge clk);
                if (done) begin lat = j; break; end
            end
            check("ignored_start_latency", lat, N - 4);
        end
        start_op(143, 11, 13, 0, 0);   // issued in the done cycle
        check("chain_done_drops", done, 0);
        check("chain_busy", busy, 1);
        wait_done();
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse
        start_op(254, 15, 16, 14, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        repeat (12) @(negedge clk);
        check("abort_q_later", q, 0);
        start_op(200, 7, 28, 4, 0);
        wait_done();
        @(negedge clk);

        // Full operand sweep
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) start_op(a, b, 255, a % 16, 1);
                else        start_op(a, b, a / b, a % b, 0);
                wait_done();
            end
        end
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
